output_vc_alloc_tracker: RTL and testbench

//  Per-output-port VC status tracker for the VC-based mesh router.
//  - Keeps one credit counter and one busy flag per downstream VC.
//  - Picks a free VC round-robin and returns its binary index, alloc_vc_bcd.
//  - The bcd_to_one_hot stage directly downstream turns that index into the
//    one-hot VC select used by the switch and VC-state registers.

---
 rtl/output_vc_alloc_tracker.sv | 100 ++++++++++
 tb/tb_output_vc_alloc_tracker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/output_vc_alloc_tracker.sv
// output_vc_alloc_tracker: per-output-port downstream VC credit/busy tracking with round-robin VC grant
module output_vc_alloc_tracker #(
    parameter int VC_BCD_WIDTH = 2,
    parameter int BUFFER_DEPTH = 4,
    parameter int CREDIT_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alloc_req,
    output logic                      alloc_gnt,
    output logic [VC_BCD_WIDTH-1:0]   alloc_vc_bcd,
    input  logic                      flit_sent_en,
    input  logic [VC_BCD_WIDTH-1:0]   flit_sent_vc_bcd,
    input  logic                      credit_in_en,
    input  logic [VC_BCD_WIDTH-1:0]   credit_in_vc_bcd,
    input  logic                      release_en,
    input  logic [VC_BCD_WIDTH-1:0]   release_vc_bcd,
    output logic [2**VC_BCD_WIDTH-1:0] vc_busy,
    output logic [2**VC_BCD_WIDTH-1:0] vc_has_credit,
    output logic                      credit_error
);
    localparam int VC_NUM = 2**VC_BCD_WIDTH;
    localparam logic [CREDIT_WIDTH-1:0] FULL = CREDIT_WIDTH'(BUFFER_DEPTH);

    logic [CREDIT_WIDTH-1:0] credit_q [VC_NUM];
    logic [CREDIT_WIDTH-1:0] credit_d [VC_NUM];
    logic [VC_NUM-1:0]       busy_q, busy_d, free, sent_hit, ret_hit;
    logic [VC_BCD_WIDTH-1:0] rr_q, rr_d, pick, idx;
    logic                    found, err_q, err_d;

    assign sent_hit = flit_sent_en ? VC_NUM'(1) << flit_sent_vc_bcd : '0;
    assign ret_hit  = credit_in_en ? VC_NUM'(1) << credit_in_vc_bcd : '0;

    // A VC is reusable only when idle and every downstream slot has drained back
    always_comb begin
        for (int i = 0; i < VC_NUM; i++) begin
            free[i]          = !busy_q[i] && credit_q[i] == FULL;
            vc_has_credit[i] = credit_q[i] != '0;
        end
    end

    // Round-robin scan for the first free VC starting at rr_q, wrapping naturally by index width
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < VC_NUM; k++) begin
            idx = rr_q + VC_BCD_WIDTH'(k);
            if (!found && free[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign alloc_gnt    = alloc_req && found && !reset;
    assign alloc_vc_bcd = alloc_gnt ? pick : '0;
    assign vc_busy      = busy_q;
    assign credit_error = err_q;

    // Next state: credit accounting, release, grant; protocol errors only raise the sticky flag
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        rr_d   = rr_q;
        for (int i = 0; i < VC_NUM; i++) begin
            credit_d[i] = credit_q[i];
            if (sent_hit[i] && !ret_hit[i]) begin
                if (credit_q[i] == '0) err_d = 1'b1;
                else credit_d[i] = credit_q[i] - 1'b1;
            end else if (ret_hit[i] && !sent_hit[i]) begin
                if (credit_q[i] == FULL) err_d = 1'b1;
                else credit_d[i] = credit_q[i] + 1'b1;
            end
        end
        if (release_en) begin
            if (!busy_q[release_vc_bcd]) err_d = 1'b1;
            else busy_d[release_vc_bcd] = 1'b0;
        end
        if (alloc_gnt) begin
            busy_d[alloc_vc_bcd] = 1'b1;
            rr_d = alloc_vc_bcd + 1'b1;
        end
    end

    // State registers with asynchronous reset to full credits and all VCs idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < VC_NUM; i++) credit_q[i] <= FULL;
            busy_q <= '0;
            rr_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            credit_q <= credit_d;
            busy_q   <= busy_d;
            rr_q     <= rr_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_output_vc_alloc_tracker.sv
// tb_output_vc_alloc_tracker: scoreboard bench for the output VC allocation tracker
module tb_output_vc_alloc_tracker;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alloc_req = 1'b0;
    logic       alloc_gnt;
    logic [1:0] alloc_vc_bcd;
    logic       flit_sent_en = 1'b0;
    logic [1:0] flit_sent_vc_bcd = '0;
    logic       credit_in_en = 1'b0;
    logic [1:0] credit_in_vc_bcd = '0;
    logic       release_en = 1'b0;
    logic [1:0] release_vc_bcd = '0;
    logic [3:0] vc_busy, vc_has_credit;
    logic       credit_error;

    output_vc_alloc_tracker #(.VC_BCD_WIDTH(2), .BUFFER_DEPTH(4), .CREDIT_WIDTH(3)) dut (
        .clk(clk), .reset(reset),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_vc_bcd(alloc_vc_bcd),
        .flit_sent_en(flit_sent_en), .flit_sent_vc_bcd(flit_sent_vc_bcd),
        .credit_in_en(credit_in_en), .credit_in_vc_bcd(credit_in_vc_bcd),
        .release_en(release_en), .release_vc_bcd(release_vc_bcd),
        .vc_busy(vc_busy), .vc_has_credit(vc_has_credit), .credit_error(credit_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      nm;
        logic       g;
        logic [1:0] v;
        logic [3:0] b;
        logic [3:0] h;
        logic       e;
    } st_t;

    st_t        sq[$];
    logic [1:0] gq[$];
    st_t        s;
    logic [1:0] ev;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always @(posedge clk) cyc++;

    // Monitor: status snapshots due this cycle, plus every grant the DUT presents
    always @(negedge clk) begin
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            s = sq.pop_front();
            n_cmp++;
            if ({alloc_gnt, alloc_vc_bcd, vc_busy, vc_has_credit, credit_error} !== {s.g, s.v, s.b, s.h, s.e}) begin
                n_bad++;
                $display("FAIL %s: got gnt=%b vc=%0d busy=%b cred=%b err=%b, want gnt=%b vc=%0d busy=%b cred=%b err=%b",
                         s.nm, alloc_gnt, alloc_vc_bcd, vc_busy, vc_has_credit, credit_error, s.g, s.v, s.b, s.h, s.e);
            end
        end
        if (alloc_gnt === 1'b1) begin
            n_cmp++;
            if (gq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_grant: got vc=%0d at cycle %0d, want no grant", alloc_vc_bcd, cyc);
            end else begin
                ev = gq.pop_front();
                if (alloc_vc_bcd !== ev) begin
                    n_bad++;
                    $display("FAIL grant_vc: got %0d, want %0d at cycle %0d", alloc_vc_bcd, ev, cyc);
                end
            end
        end
    end

    task automatic expect_st(input string nm, input logic g, input logic [1:0] v,
                             input logic [3:0] b, input logic [3:0] h, input logic e);
        st_t t;
        t.cyc = cyc; t.nm = nm; t.g = g; t.v = v; t.b = b; t.h = h; t.e = e;
        sq.push_back(t);
    endtask

    task automatic expect_gnt(input logic [1:0] v);
        gq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        alloc_req = 1'b0; flit_sent_en = 1'b0; credit_in_en = 1'b0; release_en = 1'b0;
    endtask

    task automatic snd(input logic [1:0] v);
        flit_sent_en = 1'b1; flit_sent_vc_bcd = v;
    endtask

    task automatic ret(input logic [1:0] v);
        credit_in_en = 1'b1; credit_in_vc_bcd = v;
    endtask

    task automatic rel(input logic [1:0] v);
        release_en = 1'b1; release_vc_bcd = v;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        alloc_req = 1'b1;
        expect_st("reset_state", 1'b0, 2'd0, 4'b0000, 4'b1111, 1'b0);
        tick();
        reset = 1'b0;
        // Back-to-back requests sweep all four VCs, fifth finds none free
        for (int k = 0; k < 5; k++) begin
            alloc_req = 1'b1;
            if (k < 4) expect_gnt(2'(k));
            expect_st($sformatf("rr_sweep_%0d", k), k < 4, k < 4 ? 2'(k) : 2'd0, 4'((1 << k) - 1), 4'b1111, 1'b0);
            tick();
        end
        // Drain VC1, release it, and it stays ungrantable until the last credit returns
        for (int k = 0; k < 4; k++) begin snd(2'd1); tick(); end
        rel(2'd1); alloc_req = 1'b1;
        expect_st("vc1_drained_release", 1'b0, 2'd0, 4'b1111, 4'b1101, 1'b0);
        tick();
        ret(2'd1); alloc_req = 1'b1;
        expect_st("vc1_released_no_credit", 1'b0, 2'd0, 4'b1101, 4'b1101, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin ret(2'd1); alloc_req = 1'b1; tick(); end
        ret(2'd1); alloc_req = 1'b1;
        expect_st("vc1_three_credits", 1'b0, 2'd0, 4'b1101, 4'b1111, 1'b0);
        tick();
        alloc_req = 1'b1;
        expect_gnt(2'd1);
        expect_st("vc1_regranted", 1'b1, 2'd1, 4'b1101, 4'b1111, 1'b0);
        tick();
        // Simultaneous send and return on VC2 at credit 2 leaves the counter alone
        for (int k = 0; k < 2; k++) begin snd(2'd2); tick(); end
        snd(2'd2); ret(2'd2); tick();
        expect_st("vc2_send_ret_same", 1'b0, 2'd0, 4'b1111, 4'b1111, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin snd(2'd2); tick(); end
        expect_st("vc2_credit_was_2", 1'b0, 2'd0, 4'b1111, 4'b1011, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin ret(2'd2); tick(); end
        expect_st("vc2_refilled", 1'b0, 2'd0, 4'b1111, 4'b1111, 1'b0);
        tick();
        // Underflow on VC3 holds the counter and latches the error
        for (int k = 0; k < 5; k++) begin snd(2'd3); tick(); end
        expect_st("vc3_underflow", 1'b0, 2'd0, 4'b1111, 4'b0111, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin ret(2'd3); tick(); end
        expect_st("err_sticky", 1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1);
        tick();
        // rr_ptr=2 with VC2 busy: grant VC3, then wrap to VC0
        rel(2'd0); tick();
        rel(2'd3); tick();
        expect_st("vc0_vc3_released", 1'b0, 2'd0, 4'b0110, 4'b1111, 1'b1);
        tick();
        alloc_req = 1'b1;
        expect_gnt(2'd3);
        expect_st("rr_skip_busy", 1'b1, 2'd3, 4'b0110, 4'b1111, 1'b1);
        tick();
        alloc_req = 1'b1;
        expect_gnt(2'd0);
        expect_st("rr_wrap", 1'b1, 2'd0, 4'b1110, 4'b1111, 1'b1);
        tick();
        // Mid-packet asynchronous reset with VC0 busy at credit 1
        for (int k = 0; k < 3; k++) begin snd(2'd0); tick(); end
        expect_st("vc0_mid_packet", 1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1);
        tick();
        reset = 1'b1; alloc_req = 1'b1;
        expect_st("async_reset", 1'b0, 2'd0, 4'b0000, 4'b1111, 1'b0);
        tick();
        reset = 1'b0; alloc_req = 1'b1;
        expect_gnt(2'd0);
        expect_st("post_reset_grant", 1'b1, 2'd0, 4'b0000, 4'b1111, 1'b0);
        tick();
        // Credit return on a full counter is an error and does not overflow
        ret(2'd1); tick();
        expect_st("return_overflow", 1'b0, 2'd0, 4'b0001, 4'b1111, 1'b1);
        tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        // Releasing an idle VC is an error with no state change
        rel(2'd2); tick();
        expect_st("release_idle", 1'b0, 2'd0, 4'b0000, 4'b1111, 1'b1);
        tick();
        tick();
        n_cmp++;
        if (gq.size() != 0 || sq.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d grants and %0d snapshots pending, want 0 and 0", gq.size(), sq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
